spio_spinnaker_link_tx_arbiter: RTL



---
 rtl/spio_spinnaker_link_pkg.sv | 37 +++
 rtl/spio_rr_arbiter.sv | 56 +++++
 rtl/spio_spinnaker_link_tx_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/spio_spinnaker_link_pkg.sv
// Packet layout, header bit positions and arbiter state encoding shared by the
// SpiNNaker link transmit path.
package spio_spinnaker_link_pkg;

    localparam int PKT_BITS      = 72;
    localparam int PKT_HDR_LSB   = 0;
    localparam int PKT_HDR_W     = 8;
    localparam int PKT_KEY_LSB   = 8;
    localparam int PKT_KEY_W     = 32;
    localparam int PKT_PLD_LSB   = 40;
    localparam int PKT_PLD_W     = 32;
    localparam int HDR_PLD_BIT   = 1;
    localparam int HDR_PRTY_BIT  = 0;
    localparam int BACKOFF_CNT_W = 16;

    typedef logic [PKT_BITS-1:0] pkt_t;

    typedef enum logic {
        ARB_RUN     = 1'b0,
        ARB_BACKOFF = 1'b1
    } arb_state_e;

    // Rewrites the header parity bit so that the covered bits plus parity are odd.
    function automatic pkt_t set_odd_parity(input pkt_t pkt);
        pkt_t mask;
        pkt_t res;
        mask = '0;
        mask[PKT_HDR_LSB + HDR_PRTY_BIT + 1 +: PKT_HDR_W - 1] = '1;
        mask[PKT_KEY_LSB +: PKT_KEY_W] = '1;
        if (pkt[PKT_HDR_LSB + HDR_PLD_BIT])
            mask[PKT_PLD_LSB +: PKT_PLD_W] = '1;
        res = pkt;
        res[PKT_HDR_LSB + HDR_PRTY_BIT] = ~^(pkt & mask);
        return res;
    endfunction

endpackage

// File: rtl/spio_rr_arbiter.sv
// Round-robin winner search with a rotating priority pointer; the pointer
// moves past the winner only when a grant is actually issued.
module spio_rr_arbiter #(
    parameter  int NUM_PORTS = 4,
    localparam int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [PTR_W-1:0]     gnt_idx,
    output logic                 gnt_vld
);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] cand;
    logic             found;
    int               idx;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        found = 1'b0;
        win   = '0;
        cand  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_PORTS)
                idx = idx - NUM_PORTS;
            cand = PTR_W'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        gnt     = '0;
        gnt_vld = en && found;
        gnt_idx = win;
        if (gnt_vld)
            gnt[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst)
            ptr <= '0;
        else if (gnt_vld)
            ptr <= (win == PTR_W'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
    end

endmodule

// File: rtl/spio_spinnaker_link_tx_arbiter.sv
// Round-robin arbiter sharing one SpiNNaker link sender, with a back-off window
// after sender timeouts. Define SPIO_TX_ARB_PARITY_EN to regenerate header parity on load.
module spio_spinnaker_link_tx_arbiter
    import spio_spinnaker_link_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int BACKOFF_CYCLES = 256
) (
    input  logic                          CLK_IN,
    input  logic                          RESET_IN,
    input  logic [PKT_BITS*NUM_PORTS-1:0] REQ_DATA_IN,
    input  logic [NUM_PORTS-1:0]          REQ_VLD_IN,
    output logic [NUM_PORTS-1:0]          REQ_RDY_OUT,
    output logic [PKT_BITS-1:0]           PKT_DATA_OUT,
    output logic                          PKT_VLD_OUT,
    input  logic                          PKT_RDY_IN,
    input  logic                          TMO_ERR_IN,
    output logic                          BACKOFF_OUT,
    output logic [2:0]                    GRANT_OUT
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [BACKOFF_CNT_W-1:0] BACKOFF_RELOAD = BACKOFF_CNT_W'(BACKOFF_CYCLES - 1);

    arb_state_e               state;
    arb_state_e               state_next;
    logic [BACKOFF_CNT_W-1:0] cnt;
    logic [BACKOFF_CNT_W-1:0] cnt_next;
    logic                     free;
    logic                     arb_en;
    logic                     gnt_vld;
    logic [PTR_W-1:0]         gnt_idx;
    pkt_t                     sel_pkt;
    pkt_t                     load_pkt;

    assign free   = !PKT_VLD_OUT || PKT_RDY_IN;
    // Back-off only blocks new grants; a packet already held stays offered to the sender.
    assign arb_en = free && (state == ARB_RUN) && !RESET_IN;

    spio_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr (
        .clk     (CLK_IN),
        .rst     (RESET_IN),
        .en      (arb_en),
        .req     (REQ_VLD_IN),
        .gnt     (REQ_RDY_OUT),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        sel_pkt = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt_idx == PTR_W'(i))
                sel_pkt = REQ_DATA_IN[PKT_BITS*i +: PKT_BITS];
        end
    end

`ifdef SPIO_TX_ARB_PARITY_EN
    assign load_pkt = set_odd_parity(sel_pkt);
`else
    assign load_pkt = sel_pkt;
`endif

    always_ff @(posedge CLK_IN) begin
        // NOTE: the data register is reset too, because its reset value is visible on the port.
        if (RESET_IN) begin
            PKT_VLD_OUT  <= 1'b0;
            PKT_DATA_OUT <= '0;
            GRANT_OUT    <= '0;
        end else if (gnt_vld) begin
            PKT_VLD_OUT  <= 1'b1;
            PKT_DATA_OUT <= load_pkt;
            GRANT_OUT    <= 3'(gnt_idx);
        end else if (PKT_RDY_IN) begin
            PKT_VLD_OUT  <= 1'b0;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            state <= ARB_RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A timeout during a grant cycle lets that grant finish; suppression starts next cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ARB_RUN: begin
                if (TMO_ERR_IN) begin
                    state_next = ARB_BACKOFF;
                    cnt_next   = BACKOFF_RELOAD;
                end
            end
            ARB_BACKOFF: begin
                if (TMO_ERR_IN)
                    cnt_next = BACKOFF_RELOAD;
                else if (cnt == '0)
                    state_next = ARB_RUN;
                else
                    cnt_next = cnt - 1'b1;
            end
            default: state_next = ARB_RUN;
        endcase
    end

    assign BACKOFF_OUT = (state == ARB_BACKOFF);

endmodule
